apb_regfile_slave: RTL and testbench
====================================

# apb_regfile_slave

APB completer (slave) for the color-sensor subsystem: responds to transfers driven by the APB master, holds the sensor's software-visible configuration registers and returns a hardware status word. It sits between the APB bus and the sensor datapath. It implements the response side of the bus:
- pready with programmable wait states;
- pslverr on illegal accesses;
- registered prdata.

## Interface
Parameters:
- APB_AW, 32, address bus width
- APB_DW, 32, data bus width
- NUM_REGS, 8, number of read/write registers (1..64)
- RESET_VAL, 0, reset value of every read/write register

Ports:
- clk  input  1  bus clock; all logic on its rising edge
- rst_n  input  1  reset, synchronous, active-low
- paddr  input  APB_AW  byte address
- psel  input  1  select
- penable  input  1  access phase
- pwrite  input  1  1 = write, 0 = read
- pwdata  input  APB_DW  write data
- prdata  output  APB_DW  read data, valid only while pready=1
- pready  output  1  transfer-complete acknowledge
- pslverr  output  1  error response, valid only while pready=1
- wait_cfg  input  4  wait states inserted per transfer, sampled in setup phase
- status_in  input  APB_DW  hardware status word, read-only register
- reg_out  output  NUM_REGS*APB_DW  flattened register contents; register k at bits [k*APB_DW +: APB_DW]

## Operation
Address map:
- word index = paddr[APB_AW-1:2];
- index 0..NUM_REGS-1: read/write registers;
- index NUM_REGS: status register, read-only, returns status_in.

Error rules (pslverr=1 in the completion cycle):
- paddr[1:0] != 0;
- index > NUM_REGS;
- write to the status register.

An erroring write changes no register. An erroring read returns prdata=0.

FSM states:
- IDLE: waits for setup phase, i.e. psel=1 and penable=0 sampled. On setup:
  - latch paddr, pwrite and pwdata;
  - cnt <= wait_cfg;
  - go to ACCESS.
- ACCESS: pready held 0 while cnt counts down, decrementing once per edge.
- Completion cycle: pready=1 for exactly one cycle, with prdata and pslverr valid. At the end of that cycle:
  - the write (if any, and if legal) commits to the register;
  - pready, prdata and pslverr clear to 0;
  - FSM returns to IDLE.
- Abort: if psel=0 is sampled in ACCESS before completion:
  - return to IDLE;
  - no write;
  - pready stays 0.
- penable=1 with psel=0 is ignored in every state.
- Write data and address come from the latched setup values. Changes on the bus during ACCESS do not affect the transfer.

## Timing
Reset: rst_n=0 sampled at an edge sets:
- pready=0, pslverr=0, prdata=0;
- FSM to IDLE, cnt=0;
- every register to RESET_VAL, so reg_out = all RESET_VAL.

Reset asserted mid-transfer aborts the transfer with no write.

All outputs are registered.

Setup sampled at edge E:
- pready <= (wait_cfg==0);
- prdata and pslverr are loaded at the same edge that sets pready.

Zero wait states: pready=1 in the first access cycle (between E and E+1). The transfer completes at E+1: total of 2 cycles, the APB minimum.

n wait states: pready=0 for n access cycles, then pready=1 in access cycle n+1. Completion is at edge E+n+1.

Completion-cycle details:
- Read data reflects register contents at the edge that raised pready.
- reg_out updates at the completion edge: visible in the cycle after pready=1.

Back-to-back transfers:
- A setup phase driven in the cycle after completion is sampled at the next edge. No extra idle cycle is required.
- A write followed by a read of the same register returns the new value.

wait_cfg changes take effect only at the next setup phase.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with psel=1 -> pready=0, pslverr=0, prdata=0, reg_out all 0.
- Write 0xDEADBEEF to paddr 0x08, wait_cfg=0, then read 0x08 -> pready high in the first access cycle both times, pslverr=0, prdata=0xDEADBEEF, reg_out[95:64]=0xDEADBEEF after the write.
- Wait states: wait_cfg=3, read 0x04 -> pready low for exactly 3 access cycles, high on the 4th for one cycle, and is 0 in all other cycles.
- Errors:
  - write to 0x02 -> pslverr=1, no register change;
  - read 0x40 -> pslverr=1, prdata=0;
  - write 0x20 (status) -> pslverr=1.
- Status read: status_in=0x00A5_5A00, read 0x20 -> prdata=0x00A55A00, pslverr=0.
- Abort and mid-transfer reset:
  - wait_cfg=5, write 0x11 to 0x00, drop psel after 2 access cycles -> no pready, reg 0 unchanged;
  - repeat with rst_n=0 pulsed in place of the psel drop -> all outputs 0, reg 0 = RESET_VAL.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// APB completer for the color-sensor subsystem: software-visible configuration
// registers plus a read-only hardware status word, with programmable wait
// states, error response and fully registered response outputs.
module apb_regfile_slave #(
  parameter int                APB_AW    = 32,
  parameter int                APB_DW    = 32,
  parameter int                NUM_REGS  = 8,
  parameter logic [APB_DW-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [APB_AW-1:0]          paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [APB_DW-1:0]          pwdata,
  output logic [APB_DW-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  input  logic [3:0]                 wait_cfg,
  input  logic [APB_DW-1:0]          status_in,
  output logic [NUM_REGS*APB_DW-1:0] reg_out
);

  localparam int IDX_W = APB_AW - 2;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [APB_AW-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [APB_DW-1:0]   wdata_q, wdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [APB_DW-1:0]   prdata_q, prdata_d;
  logic [APB_DW-1:0]   regs_q [NUM_REGS];
  logic [APB_DW-1:0]   regs_d [NUM_REGS];

  // Address/direction under decode: the live bus while the setup phase is
  // being sampled (zero-wait response), the latched values afterwards.
  logic [APB_AW-1:0]   cur_addr;
  logic                cur_write;
  logic [IDX_W-1:0]    cur_idx;
  logic                cur_err;
  logic [APB_DW-1:0]   cur_rdata;
  logic                load_resp;

  // Decode of the transfer in flight: error classification and read mux.
  always_comb begin
    cur_addr  = (state_q == IDLE) ? paddr  : addr_q;
    cur_write = (state_q == IDLE) ? pwrite : write_q;
    cur_idx   = cur_addr[APB_AW-1:2];
    cur_err   = (cur_addr[1:0] != 2'b00) || (cur_idx > STATUS_IDX) ||
                (cur_write && (cur_idx == STATUS_IDX));
    cur_rdata = '0;
    if (cur_idx == STATUS_IDX) begin
      cur_rdata = status_in;
    end
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cur_idx == IDX_W'(k)) begin
        cur_rdata = regs_q[k];
      end
    end
  end

  // Next-state logic: setup latch, wait-state countdown, abort and commit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    regs_d    = regs_q;
    load_resp = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          cnt_d   = wait_cfg;
          state_d = ACCESS;
          load_resp = (wait_cfg == 4'd0);
        end
      end
      ACCESS: begin
        if (pready_q) begin
          // Completion edge: commit a legal write, then back to idle.
          if (write_q && !pslverr_q) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (addr_q[APB_AW-1:2] == IDX_W'(k)) begin
                regs_d[k] = wdata_q;
              end
            end
          end
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (!psel) begin
          // Master abandoned the transfer before completion.
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          cnt_d     = 4'd0;
          load_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_resp) begin
      pready_d  = 1'b1;
      pslverr_d = cur_err;
      prdata_d  = (cur_err || cur_write) ? '0 : cur_rdata;
    end
  end

  // State, response and register-file storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VAL;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      regs_q    <= regs_d;
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*APB_DW +: APB_DW] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Randomized bench for apb_regfile_slave against an array-based register model.
module tb_apb_regfile_slave;

  localparam int          AW = 32;
  localparam int          DW = 32;
  localparam int          NR = 8;
  localparam logic [31:0] RV = 32'h0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     paddr;
  logic              psel, penable, pwrite;
  logic [DW-1:0]     pwdata, prdata, status_in;
  logic              pready, pslverr;
  logic [3:0]        wait_cfg;
  logic [NR*DW-1:0]  reg_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [NR];

  always #5 clk = ~clk;

  apb_regfile_slave #(
    .APB_AW(AW), .APB_DW(DW), .NUM_REGS(NR), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .wait_cfg(wait_cfg), .status_in(status_in),
    .reg_out(reg_out)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < NR; k++) check(tag, reg_out[k*DW +: DW], mdl[k]);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_pready"}, pready, 1'b0);
    check({tag, "_pslverr"}, pslverr, 1'b0);
    check({tag, "_prdata"}, prdata, 32'h0);
  endtask

  // One complete transfer; the next setup may follow immediately.
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd, input int waits);
    int unsigned idx;
    logic exp_err;
    logic [31:0] exp_rd;
    int n;
    idx     = addr >> 2;
    exp_err = (addr[1:0] != 2'b00) || (idx > NR) || (wr && idx == NR);
    exp_rd  = (exp_err || wr) ? 32'h0 : ((idx == NR) ? status_in : mdl[idx]);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
    wait_cfg = waits[3:0];
    @(negedge clk);
    check("setup_pready", pready, 1'b0);
    check_regs("reg_out");
    @(posedge clk); #1;
    // Bus noise during access must not affect the latched transfer.
    penable = 1'b1; paddr = $urandom; pwdata = $urandom; wait_cfg = 4'($urandom);
    n = 0;
    @(negedge clk);
    while (pready !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("wait_states", n, waits);
    check("pslverr", pslverr, exp_err);
    check("prdata", prdata, exp_rd);
    if (wr && !exp_err) mdl[idx] = wd;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'($urandom); paddr = $urandom; pwrite = 1'($urandom);
      @(negedge clk);
      check_quiet("idle");
    end
  endtask

  // Transfer abandoned after k access cycles, by psel drop or reset pulse.
  task automatic abort_xfer(input logic [31:0] addr, input logic [31:0] wd, input int waits,
                            input int k, input bit use_reset);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = 1'b1; pwdata = wd;
    wait_cfg = waits[3:0];
    @(negedge clk);
    check("abort_setup_pready", pready, 1'b0);
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (k) begin
      @(negedge clk);
      check("abort_wait_pready", pready, 1'b0);
    end
    @(posedge clk); #1;
    if (use_reset) rst_n = 1'b0;
    else begin psel = 1'b0; penable = 1'b0; end
    @(negedge clk);
    check("abort_pready", pready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    if (use_reset) for (int r = 0; r < NR; r++) mdl[r] = RV;
    repeat (waits + 2) begin
      @(negedge clk);
      check_quiet("post_abort");
    end
    check_regs("abort_regs");
  endtask

  initial begin
    int waits, kk, r;
    logic [31:0] a;
    rst_n = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; wait_cfg = 4'd0; status_in = 32'h0;
    for (int k = 0; k < NR; k++) mdl[k] = RV;

    // Reset held with psel asserted.
    repeat (3) begin
      @(negedge clk);
      check_quiet("reset");
    end
    check_regs("reset_regs");
    @(posedge clk); #1;
    rst_n = 1'b1; psel = 1'b0;

    // Zero-wait write/read, back to back.
    xfer(32'h08, 1'b1, 32'hDEADBEEF, 0);
    xfer(32'h08, 1'b0, 32'h0, 0);
    check("reg2_slice", reg_out[95:64], 32'hDEADBEEF);
    idle(1);

    // Three wait states.
    xfer(32'h04, 1'b0, 32'h0, 3);
    idle(2);

    // Error responses.
    xfer(32'h02, 1'b1, 32'h12345678, 0);
    xfer(32'h40, 1'b0, 32'h0, 1);
    xfer(32'h20, 1'b1, 32'hFFFFFFFF, 2);
    idle(1);
    check_regs("after_errors");

    // Status read.
    status_in = 32'h00A55A00;
    xfer(32'h20, 1'b0, 32'h0, 0);
    idle(1);

    // Abort by psel drop, then by reset pulse.
    xfer(32'h00, 1'b1, 32'h55, 0);
    idle(1);
    abort_xfer(32'h00, 32'h11, 5, 2, 1'b0);
    xfer(32'h00, 1'b1, 32'h66, 1);
    abort_xfer(32'h00, 32'h11, 5, 2, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, NR)) * 32'd4;
      else if (r == 8) a = 32'($urandom_range(0, 63));
      else             a = $urandom;
      waits = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4);
      status_in = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        waits = $urandom_range(3, 8);
        kk = $urandom_range(1, waits - 2);
        abort_xfer(32'($urandom_range(0, NR - 1)) * 32'd4, $urandom, waits, kk, 1'($urandom));
      end else begin
        xfer(a, 1'($urandom), $urandom, waits);
      end
      idle($urandom_range(0, 2));
    end
    idle(1);
    check_regs("final_regs");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
